// File: rtl/nes_pad_reader_pkg.sv
// Shared constants and types for the NES controller poller: button bit
// positions, poll FSM states and default pad timing.
package nes_pad_reader_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam int DEF_HALF_PERIOD  = 150;
   localparam int DEF_LATCH_CYCLES = 300;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } poll_state_e;

   // Phase counters load N-1 and count down, so clog2 of the longest phase suffices.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/nes_pad_reader_vsync_tick.sv
// Rising-edge detector on vertical_sync: one-cycle frame tick while the
// input is high and its registered history is low.
module vsync_tick (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync_i,
   output logic tick_o
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= vsync_i;
   end

   assign tick_o = vsync_i & ~prev_q;

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES serial controller once per frame and publishes registered,
// active-high button state plus the paddle move commands.
module nes_pad_reader
   import nes_pad_reader_pkg::*;
#(
   parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
   input  logic       pixel_clock,
   input  logic       reset_n,
   input  logic       vertical_sync,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clock,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       move_forward,
   output logic       move_backward
);

   localparam int CNT_W = cnt_width(HALF_PERIOD, LATCH_CYCLES);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

   poll_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       buttons_q;
   logic             sync1_q, sync2_q;
   logic             latch_q, clk_q, valid_q;
   logic             frame_tick;
   logic             sample;

   vsync_tick u_vsync_tick (
      .clk     (pixel_clock),
      .rst_n   (reset_n),
      .vsync_i (vertical_sync),
      .tick_o  (frame_tick)
   );

   // pad_data is asynchronous; idle line is high (no button pressed).
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pad_data;
         sync2_q <= sync1_q;
      end
   end

   assign sample = ~sync2_q;

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               state_d = ST_LATCH;
               cnt_d   = LATCH_LOAD;
            end
         end
         ST_LATCH: begin
            if (cnt_q == '0) begin
               state_d = ST_LOW;
               cnt_d   = HALF_LOAD;
               idx_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (cnt_q == '0) begin
               shift_d[idx_q] = sample;
               cnt_d          = HALF_LOAD;
               state_d        = (idx_q == 3'd7) ? ST_DONE : ST_HIGH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (cnt_q == '0) begin
               state_d = ST_LOW;
               cnt_d   = HALF_LOAD;
               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pad strobes are decoded from the next state so they switch on the same
   // edge as the FSM and stay glitch-free; they are never both high.
   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         latch_q   <= 1'b0;
         clk_q     <= 1'b0;
         valid_q   <= 1'b0;
         buttons_q <= '0;
      end else begin
         latch_q <= (state_d == ST_LATCH);
         clk_q   <= (state_d == ST_HIGH);
         valid_q <= (state_q == ST_DONE);
         if (state_q == ST_DONE) buttons_q <= shift_q;
      end
   end

   assign pad_latch     = latch_q;
   assign pad_clock     = clk_q;
   assign buttons       = buttons_q;
   assign buttons_valid = valid_q;
   assign move_forward  = buttons_q[BTN_DOWN];
   assign move_backward = buttons_q[BTN_UP];

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Polls one NES-style serial game controller once per video frame.
- Converts its 8 active-low button bits into registered, active-high button state.
- Drives the paddle movement commands move_forward/move_backward from the Down/Up buttons.
- Sits between the board controller pins and the paddle position logic, in the pixel_clock domain.

Parameters:
- HALF_PERIOD, 150: pixel_clock cycles per pad_clock low or high phase (about 6 us at 25.175 MHz). Must be >= 3.
- LATCH_CYCLES, 300: pixel_clock cycles pad_latch is held high. Must be >= 3.

Ports:
- pixel_clock  input  1  sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- vertical_sync  input  1  frame sync; a poll starts on each rising edge.
- pad_data  input  1  serial data from controller, active-low, asynchronous to pixel_clock.
- pad_latch  output  1  parallel-load strobe to controller, active-high.
- pad_clock  output  1  shift clock to controller; controller advances on its rising edge.
- buttons  output  8  active-high button state. Bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- buttons_valid  output  1  one-cycle pulse when buttons updates.
- move_forward  output  1  equals buttons[5] (Down).
- move_backward  output  1  equals buttons[4] (Up).

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - all outputs 0;
  - state IDLE; counters 0;
  - vsync history register 0; pad_data synchronizer flops 1.
- pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value; a sample takes the inverse of that value.
- Rising edge detection: vertical_sync high while the registered previous value is low.
  - The edge is acted on only in IDLE.
  - Edges in any other state are dropped, not queued.
  - A vertical_sync held high produces exactly one poll.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE: on a detected edge, go to LATCH. pad_latch rises on the next clock edge after the edge-detection cycle.
  - LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles, then go to LOW with bit index 0.
  - LOW: pad_clock=0 for HALF_PERIOD cycles. On the last cycle, capture the sample into shift bit[index].
    - If index=7, go to DONE.
    - Otherwise go to HIGH.
  - HIGH: pad_clock=1 for HALF_PERIOD cycles, then index+1 and go to LOW.
  - DONE: one cycle. Load buttons from the shift register, pulse buttons_valid=1, go to IDLE.
- Exactly 7 pad_clock pulses per poll. pad_latch and pad_clock are registered outputs, glitch-free, and never high simultaneously.
- Poll length: LATCH_CYCLES + 8*HALF_PERIOD + 7*HALF_PERIOD + 1 cycles. Default is 2551, well under one frame.
- buttons, move_forward and move_backward change only in DONE and hold between polls.
- If Up and Down are both pressed, both move outputs are 1.
- Phase counter width is clog2(max(HALF_PERIOD, LATCH_CYCLES)). Counters count down to 0; no wrap beyond terminal count.
- Reset mid-poll: abort immediately with all outputs 0 and no partial buttons update. The next vertical_sync edge after release starts a fresh poll.

Decomposition:
- Shared package holds:
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - FSM state enum;
  - default timing constants.
- One natural sub-module, vsync_tick: vertical_sync edge detector with asynchronous active-low reset, producing a one-cycle frame tick. The paddle logic can reuse it.

Test Plan:
Bench uses HALF_PERIOD=4 and LATCH_CYCLES=8. Controller model: parallel-loads on pad_latch, shifts on pad_clock rising edge, and drives its bit 0 (active-low) combinationally onto pad_data.
- Reset asserted, then released with vertical_sync low -> pad_latch=0, pad_clock=0, buttons=8'h00, move_forward=0, move_backward=0, buttons_valid=0.
- Model holds Down (8'h20); one vertical_sync rising edge -> all of:
  - pad_latch high for exactly 8 cycles;
  - 7 pad_clock pulses, each 4 cycles high;
  - buttons=8'h20, move_forward=1, move_backward=0;
  - a single buttons_valid pulse 8+60+1=69 cycles after pad_latch rises.
- Model holds Up+Down+A (8'h31) -> buttons=8'h31, move_forward=1, move_backward=1.
- Second vertical_sync rising edge 20 cycles after the first -> only one pad_latch pulse and one buttons_valid pulse; buttons equals the first sample.
- vertical_sync held high for 500 cycles, model changes to 8'h10 mid-hold -> no new poll. buttons stays at its prior value until the next rising edge, then reads 8'h10 with move_backward=1.
- reset_n pulsed low during the 3rd pad_clock pulse:
  - pad_clock and pad_latch drop to 0 the same instant;
  - buttons=0; no buttons_valid pulse;
  - the next vertical_sync edge yields a complete, correct poll.
